// File: rtl/ibex_vec_ex_seq.sv
// ibex_vec_ex_seq: multi-beat vector integer execute sequencer.
// Accepts one vector operation (ADD/SUB/AND/OR/XOR/MIN/MAX/REDSUM) at a time,
// processes it 32*LANES bits per beat over NBEATS beats, then holds the result
// until the consumer takes it.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   valid_i/ready_o          operation offer / block idle and able to accept
//   op_i, vsew_i, vl_i       operation code, element width, active element count
//   vs1_i, vs2_i, vd_old_i   source operands and old destination value
//   kill_i                   synchronous flush, highest priority
//   valid_o/ready_i          result valid / consumer accepts
//   result_o, illegal_o      result vector, illegal-operation flag (with valid_o)
module ibex_vec_ex_seq #(
  parameter int unsigned VLEN  = 128,
  parameter int unsigned LANES = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [2:0]                 op_i,
  input  logic [1:0]                 vsew_i,
  input  logic [$clog2(VLEN/8):0]    vl_i,
  input  logic [VLEN-1:0]            vs1_i,
  input  logic [VLEN-1:0]            vs2_i,
  input  logic [VLEN-1:0]            vd_old_i,
  input  logic                       kill_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [VLEN-1:0]            result_o,
  output logic                       illegal_o
);

  localparam int unsigned NBEATS = VLEN / (32 * LANES);
  localparam int unsigned BW     = 32 * LANES;
  localparam int unsigned VLW    = $clog2(VLEN/8) + 1;
  localparam int unsigned CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [VLW-1:0] VLMAX8  = VLW'(VLEN/8);
  localparam logic [VLW-1:0] VLMAX16 = VLW'(VLEN/16);
  localparam logic [VLW-1:0] VLMAX32 = VLW'(VLEN/32);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q;
  logic [1:0]       sew_q;
  logic [VLW-1:0]   vl_q;
  logic [VLEN-1:0]  vs1_q, vs2_q;
  logic [VLEN-1:0]  result_q, result_d;
  logic [CW-1:0]    cnt_q;
  logic [31:0]      acc_q, acc_d;
  logic             illegal_q;

  logic             accept, skip, last_beat;
  logic [VLW-1:0]   vlmax, vl_eff;
  logic [BW-1:0]    s1, s2, sd, beat_res;
  logic [31:0]      bsum, red, r;

  // Upper operand bits are zero, so ADD/SUB wrap correctly once truncated to SEW.
  function automatic logic [31:0] elem_op(input logic [2:0] op, input logic [1:0] sew,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0]        res;
    case (sew)
      2'b00:   begin sa = {{24{a[7]}},  a[7:0]};  sb = {{24{b[7]}},  b[7:0]};  end
      2'b01:   begin sa = {{16{a[15]}}, a[15:0]}; sb = {{16{b[15]}}, b[15:0]}; end
      default: begin sa = a;                      sb = b;                      end
    endcase
    case (op)
      3'd0:    res = a + b;
      3'd1:    res = a - b;
      3'd2:    res = a & b;
      3'd3:    res = a | b;
      3'd4:    res = a ^ b;
      3'd5:    res = (sa < sb) ? a : b;
      3'd6:    res = (sa > sb) ? a : b;
      default: res = a;
    endcase
    return res;
  endfunction

  always_comb begin
    case (vsew_i)
      2'b00:   vlmax = VLMAX8;
      2'b01:   vlmax = VLMAX16;
      default: vlmax = VLMAX32;
    endcase
    vl_eff = (vl_i > vlmax) ? vlmax : vl_i;
  end

  assign skip      = (vsew_i == 2'b11) || (vl_eff == '0);
  assign accept    = valid_i && ready_o && !kill_i;
  assign last_beat = (cnt_q == CW'(NBEATS-1));

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (kill_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (valid_i) state_d = skip ? DONE : EXEC;
        EXEC:    if (last_beat) state_d = DONE;
        DONE:    if (ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    ready_o   = (state_q == IDLE);
    valid_o   = (state_q == DONE);
    illegal_o = illegal_q;
    result_o  = result_q;
  end

  // Beat datapath: current slice of each operand, elementwise result and
  // partial reduction sum of the active elements in this slice.
  always_comb begin
    s1 = '0;
    s2 = '0;
    sd = '0;
    for (int unsigned b = 0; b < NBEATS; b++) begin
      if (cnt_q == CW'(b)) begin
        s1 = vs1_q[b*BW +: BW];
        s2 = vs2_q[b*BW +: BW];
        sd = result_q[b*BW +: BW];
      end
    end
    beat_res = sd;
    bsum     = '0;
    r        = '0;
    case (sew_q)
      2'b00: begin
        for (int unsigned e = 0; e < BW/8; e++) begin
          if ((32'(cnt_q) * (BW/8) + e) < 32'(vl_q)) begin
            r = elem_op(op_q, sew_q, 32'(s2[e*8 +: 8]), 32'(s1[e*8 +: 8]));
            beat_res[e*8 +: 8] = r[7:0];
            bsum = bsum + 32'(s2[e*8 +: 8]);
          end
        end
      end
      2'b01: begin
        for (int unsigned e = 0; e < BW/16; e++) begin
          if ((32'(cnt_q) * (BW/16) + e) < 32'(vl_q)) begin
            r = elem_op(op_q, sew_q, 32'(s2[e*16 +: 16]), 32'(s1[e*16 +: 16]));
            beat_res[e*16 +: 16] = r[15:0];
            bsum = bsum + 32'(s2[e*16 +: 16]);
          end
        end
      end
      default: begin
        for (int unsigned e = 0; e < BW/32; e++) begin
          if ((32'(cnt_q) * (BW/32) + e) < 32'(vl_q)) begin
            r = elem_op(op_q, sew_q, s2[e*32 +: 32], s1[e*32 +: 32]);
            beat_res[e*32 +: 32] = r;
            bsum = bsum + s2[e*32 +: 32];
          end
        end
      end
    endcase

    acc_d = acc_q + bsum;
    case (sew_q)
      2'b00:   red = acc_d + 32'(vs1_q[7:0]);
      2'b01:   red = acc_d + 32'(vs1_q[15:0]);
      default: red = acc_d + vs1_q[31:0];
    endcase

    // result_q was preloaded with vd_old, so tail and non-element-0 REDSUM
    // positions are already correct and only active data is overwritten.
    result_d = result_q;
    if (op_q != 3'd7) begin
      for (int unsigned b = 0; b < NBEATS; b++) begin
        if (cnt_q == CW'(b)) result_d[b*BW +: BW] = beat_res;
      end
    end else if (last_beat) begin
      case (sew_q)
        2'b00:   result_d[7:0]  = red[7:0];
        2'b01:   result_d[15:0] = red[15:0];
        default: result_d[31:0] = red;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q      <= '0;
      sew_q     <= '0;
      vl_q      <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      op_q      <= op_i;
      sew_q     <= vsew_i;
      vl_q      <= vl_eff;
      vs1_q     <= vs1_i;
      vs2_q     <= vs2_i;
      result_q  <= vd_old_i;
      cnt_q     <= '0;
      acc_q     <= '0;
      illegal_q <= (vsew_i == 2'b11);
    end else if (state_q == EXEC && !kill_i) begin
      result_q  <= result_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_ibex_vec_ex_seq.sv
module tb_ibex_vec_ex_seq;

  localparam int VLEN = 128;
  localparam int VLW  = 5;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic [2:0]       op_i = '0;
  logic [1:0]       vsew_i = '0;
  logic [VLW-1:0]   vl_i = '0;
  logic [VLEN-1:0]  vs1_i = '0, vs2_i = '0, vd_old_i = '0;
  logic             kill_i = 1'b0;
  logic             valid_o;
  logic             ready_i = 1'b0;
  logic [VLEN-1:0]  result_o;
  logic             illegal_o;

  int errors = 0;
  int checks = 0;

  ibex_vec_ex_seq #(.VLEN(128), .LANES(1)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .vsew_i(vsew_i), .vl_i(vl_i), .vs1_i(vs1_i), .vs2_i(vs2_i),
    .vd_old_i(vd_old_i), .kill_i(kill_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [2:0]     op;
    logic [1:0]     sew;
    logic [VLW-1:0] vl;
    logic [127:0]   vs1, vs2, vd;
    logic [127:0]   exp_res;
    logic           exp_ill;
    int             exp_lat;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: element-by-element arithmetic on integers.
  function automatic longint get_el(input logic [127:0] v, input int i, input int s);
    logic [127:0] t;
    t = v >> (i * s);
    return longint'(t[31:0]) & ((64'sd1 <<< s) - 1);
  endfunction

  function automatic logic [127:0] put_el(input logic [127:0] v, input int i, input int s,
                                          input longint x);
    logic [127:0] m, xv;
    m  = ((128'd1 << s) - 1) << (i * s);
    xv = (128'(x) & ((128'd1 << s) - 1)) << (i * s);
    return (v & ~m) | xv;
  endfunction

  function automatic longint sx(input longint x, input int s);
    return (x >= (64'sd1 <<< (s - 1))) ? x - (64'sd1 <<< s) : x;
  endfunction

  task automatic ref_op(input logic [2:0] op, input logic [1:0] sew, input int vl,
                        input logic [127:0] a1, input logic [127:0] a2, input logic [127:0] vd,
                        output logic [127:0] res, output logic ill, output int lat);
    int s, vle;
    longint x, y, z, sum;
    s   = 8 << sew;
    vle = (vl < 128 / s) ? vl : 128 / s;
    res = vd;
    ill = (sew == 2'b11);
    lat = 1;
    if (sew == 2'b11 || vle == 0) return;
    lat = 5;
    if (op == 3'd7) begin
      sum = get_el(a1, 0, s);
      for (int i = 0; i < vle; i++) sum += get_el(a2, i, s);
      res = put_el(res, 0, s, sum);
    end else begin
      for (int i = 0; i < vle; i++) begin
        x = get_el(a2, i, s);
        y = get_el(a1, i, s);
        case (op)
          3'd0: z = x + y;
          3'd1: z = x - y;
          3'd2: z = x & y;
          3'd3: z = x | y;
          3'd4: z = x ^ y;
          3'd5: z = (sx(x, s) < sx(y, s)) ? x : y;
          default: z = (sx(x, s) > sx(y, s)) ? x : y;
        endcase
        res = put_el(res, i, s, z);
      end
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer one operation, scramble the inputs after accept, wait (bounded)
  // for valid_o, capture result and latency, then complete the handshake.
  task automatic run_op(input logic [2:0] op, input logic [1:0] sew, input logic [VLW-1:0] vl,
                        input logic [127:0] a1, input logic [127:0] a2, input logic [127:0] vd,
                        output logic [127:0] res, output logic ill, output int lat);
    @(negedge clk);
    op_i = op; vsew_i = sew; vl_i = vl; vs1_i = a1; vs2_i = a2; vd_old_i = vd;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    op_i = 3'($urandom); vsew_i = 2'($urandom); vl_i = VLW'($urandom);
    vs1_i = rnd128(); vs2_i = rnd128(); vd_old_i = rnd128();
    lat = 1;
    while (!valid_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result_o;
    ill = illegal_o;
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
  endtask

  initial begin
    logic [127:0] res, eres, hold;
    logic         ill, eill;
    int           lat, elat, n;
    logic [2:0]   rop;
    logic [1:0]   rsew;
    logic [VLW-1:0] rvl;
    logic [127:0] r1, r2, rd;
    bit           seen;

    tbl[0] = '{"add_wrap", 3'd0, 2'b00, 5'd16, {16{8'h02}}, {16{8'hFF}}, 128'h0,
               {16{8'h01}}, 1'b0, 5};
    tbl[1] = '{"sub_tail", 3'd1, 2'b10, 5'd2, {4{32'h1}},
               128'h00000004_00000003_00000002_00000001, {4{32'hAAAAAAAA}},
               128'hAAAAAAAA_AAAAAAAA_00000001_00000000, 1'b0, 5};
    tbl[2] = '{"redsum", 3'd7, 2'b01, 5'd20, 128'h5, {8{16'h1000}}, {8{16'hBEEF}},
               {{7{16'hBEEF}}, 16'h8005}, 1'b0, 5};
    tbl[3] = '{"vl_zero", 3'd0, 2'b00, 5'd0, {4{32'h11111111}}, {4{32'h22222222}},
               128'h0123456789ABCDEF_FEDCBA9876543210,
               128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0, 1};
    tbl[4] = '{"sew_rsvd", 3'd0, 2'b11, 5'd4, {4{32'h1}}, {4{32'h2}}, {4{32'hCAFEF00D}},
               {4{32'hCAFEF00D}}, 1'b1, 1};
    tbl[5] = '{"min8", 3'd5, 2'b00, 5'd1, 128'h7F, 128'h80, {16{8'h11}},
               {{15{8'h11}}, 8'h80}, 1'b0, 5};

    rst_ni = 1'b0;
    #23;
    chk("rst_ready", 128'(ready_o), 128'd1);
    chk("rst_valid", 128'(valid_o), 128'd0);
    chk("rst_illegal", 128'(illegal_o), 128'd0);
    chk("rst_result", result_o, 128'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].op, tbl[i].sew, tbl[i].vl, tbl[i].vs1, tbl[i].vs2, tbl[i].vd, res, ill, lat);
      chk({tbl[i].name, "_res"}, res, tbl[i].exp_res);
      chk({tbl[i].name, "_ill"}, 128'(ill), 128'(tbl[i].exp_ill));
      chk({tbl[i].name, "_lat"}, 128'(lat), 128'(tbl[i].exp_lat));
    end

    for (int i = 0; i < 25; i++) begin
      rop = 3'($urandom_range(0, 7));
      rsew = 2'($urandom_range(0, 3));
      rvl = VLW'($urandom_range(0, 31));
      r1 = rnd128(); r2 = rnd128(); rd = rnd128();
      ref_op(rop, rsew, int'(rvl), r1, r2, rd, eres, eill, elat);
      run_op(rop, rsew, rvl, r1, r2, rd, res, ill, lat);
      chk($sformatf("rnd%0d_res", i), res, eres);
      chk($sformatf("rnd%0d_ill", i), 128'(ill), 128'(eill));
      chk($sformatf("rnd%0d_lat", i), 128'(lat), 128'(elat));
    end

    // Backpressure: result held stable while ready_i is low.
    r1 = rnd128(); r2 = rnd128(); rd = rnd128();
    ref_op(3'd0, 2'b10, 4, r1, r2, rd, eres, eill, elat);
    @(negedge clk);
    op_i = 3'd0; vsew_i = 2'b10; vl_i = 5'd4; vs1_i = r1; vs2_i = r2; vd_old_i = rd;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    n = 1;
    while (!valid_o && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_first", result_o, eres);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_valid%0d", c), 128'(valid_o), 128'd1);
      chk($sformatf("bp_hold%0d", c), result_o, eres);
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk("bp_after_valid", 128'(valid_o), 128'd0);
    chk("bp_after_ready", 128'(ready_o), 128'd1);

    // Kill during beat 2.
    @(negedge clk);
    op_i = 3'd0; vsew_i = 2'b00; vl_i = 5'd16; vs1_i = rnd128(); vs2_i = rnd128();
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    kill_i = 1'b1;
    @(posedge clk); #1;
    kill_i = 1'b0;
    chk("kill_ready", 128'(ready_o), 128'd1);
    chk("kill_valid", 128'(valid_o), 128'd0);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (valid_o) seen = 1'b1;
    end
    chk("kill_no_result", 128'(seen), 128'd0);

    // Offer coincident with kill is dropped.
    @(negedge clk);
    valid_i = 1'b1;
    kill_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    kill_i = 1'b0;
    chk("kill_offer_dropped", 128'(ready_o), 128'd1);

    // Reset at beat 1, then a fresh ADD.
    @(negedge clk);
    op_i = 3'd1; vsew_i = 2'b01; vl_i = 5'd8; vs1_i = rnd128(); vs2_i = rnd128();
    vd_old_i = rnd128();
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b0;
    #1;
    chk("midrst_ready", 128'(ready_o), 128'd1);
    chk("midrst_valid", 128'(valid_o), 128'd0);
    chk("midrst_result", result_o, 128'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    r1 = rnd128(); r2 = rnd128(); rd = rnd128();
    ref_op(3'd0, 2'b00, 10, r1, r2, rd, eres, eill, elat);
    run_op(3'd0, 2'b00, 5'd10, r1, r2, rd, res, ill, lat);
    chk("postrst_res", res, eres);
    chk("postrst_lat", 128'(lat), 128'(elat));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
